rs_ts_out_buffer: RTL and testbench
===================================

# rs_ts_out_buffer

Downstream stage of the RS(204,188) decoder. Takes the decoder's byte stream, qualified per byte by the CEO/Valid_out pair, and frames it into 188-byte MPEG-TS packets. It checks the 0x47 sync byte and buffers whole packets in an internal FIFO. Packets leave on a valid/ready byte interface, so the sink may stall without losing mid-packet data.

## Interface
- DEPTH_LOG2, 9: FIFO depth is 2**DEPTH_LOG2 entries. Must satisfy 2**DEPTH_LOG2 >= BLOCK_LEN.
- BLOCK_LEN, 188: bytes per packet.
- SYNC_BYTE, 8'h47: expected value of byte 0.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- CE  in  1  byte strobe, driven from the decoder's CEO.
- Valid_in  in  1  block valid, driven from the decoder's Valid_out.
- input_byte  in  8  decoded byte.
- ts_ready  in  1  sink can accept a byte.
- ts_data  out  8  output byte.
- ts_valid  out  1  ts_data is valid.
- ts_sop  out  1  current output byte is packet byte 0.
- ts_eop  out  1  current output byte is packet byte BLOCK_LEN-1.
- ts_err  out  1  current output byte belongs to a packet whose byte 0 != SYNC_BYTE.
- pkt_drop  out  1  one-cycle pulse when an incoming packet is discarded.
- overflow_flag  out  1  sticky; set by any pkt_drop, cleared only by reset.
- level  out  DEPTH_LOG2+1  current FIFO occupancy in entries.

## Operation
- Accepted byte: CE && Valid_in at a clk edge. CE with Valid_in low is ignored, and the counters do not move.
- in_cnt (0..BLOCK_LEN-1) advances on every accepted byte and wraps from BLOCK_LEN-1 to 0. It is reset only by reset.
- Input FSM states: IDLE, STORE, DROP.
  - IDLE, accepted byte with in_cnt==0:
    - If free = 2**DEPTH_LOG2 - level >= BLOCK_LEN: go to STORE, write the byte, latch err_tag = (input_byte != SYNC_BYTE).
    - Otherwise: go to DROP and pulse pkt_drop.
  - STORE: write every accepted byte, tagged with err_tag.
  - DROP: discard every accepted byte.
  - Both STORE and DROP return to IDLE after the byte with in_cnt==BLOCK_LEN-1.
- FIFO entry is 11 bits: {err, eop, sop, data}. sop is set for in_cnt==0 and eop for in_cnt==BLOCK_LEN-1.
- The admission check guarantees no write ever happens while the FIFO is full. There is no mid-packet overflow.
- Output is show-ahead:
  - ts_valid is high whenever the output register holds an entry.
  - A transfer occurs on ts_valid && ts_ready.
  - While ts_valid && !ts_ready, ts_data, ts_sop, ts_eop and ts_err hold stable.
- Pointers are binary with wrap-around at 2**DEPTH_LOG2.
- level counts entries in memory plus the output register: +1 on a write, -1 on a transfer, unchanged when both occur in the same cycle.

## Timing
- Reset values: ts_data=0, ts_valid=0, ts_sop=0, ts_eop=0, ts_err=0, pkt_drop=0, overflow_flag=0, level=0. Internally, in_cnt=0 and FSM=IDLE.
- Reset asserted mid-operation clears everything immediately and asynchronously. All buffered data is lost.
- First-word latency: a byte written at edge N into an empty FIFO gives ts_valid=1 after edge N+1.
- Throughput: one transfer per clk while data is available and ts_ready=1.
- pkt_drop is high for exactly the cycle after the rejected byte 0 edge.
- The admission decision uses level before that edge's update. A transfer in the same cycle does not count toward free space.

## Test plan
- Nominal packet:
  - Stimulus: reset, then one packet with bytes 0x47,0x01..0xBB; CE pulsed 1 clk in every 8; Valid_in=1; ts_ready=1.
  - Response: 188 transfers in order; ts_sop only on 0x47; ts_eop only on 0xBB; ts_err=0; level returns to 0.
- Sync error:
  - Stimulus: packet with byte 0 = 0x00.
  - Response: all 188 output bytes have ts_err=1. The next packet, starting with 0x47, has ts_err=0.
- Drop on full:
  - Stimulus: ts_ready=0, DEPTH_LOG2=9, three packets.
  - Response: level=376 after packet 2. Packet 3 produces pkt_drop one cycle after its byte 0, overflow_flag=1, level stays 376. Then raising ts_ready yields exactly 376 transfers with 2 sop and 2 eop.
- Backpressure:
  - Stimulus: ts_ready toggling 1,0,0,1 repeatedly.
  - Response: ts_data is unchanged across every stalled cycle; no byte is lost or duplicated against the expected sequence.
- Reset mid-packet:
  - Stimulus: assert reset after 100 accepted bytes, release it, then send a full packet.
  - Response: all outputs are at reset values; then exactly 188 bytes are output, with sop on the first.
- Gated CE:
  - Stimulus: 20 CE pulses with Valid_in=0.
  - Response: level=0, ts_valid=0, and in_cnt unchanged, so the following valid packet is framed from byte 0.

Source files
------------

// File: rtl/rs_ts_out_buffer_if.sv
// Byte-stream bundle for the RS decoder output buffer.
//
// Handshake rules:
//   Input side  - a byte is accepted on a rising clk edge where CE && Valid_in
//                 are both high; there is no back-pressure towards the decoder.
//   Output side - ts_valid/ts_ready: a transfer happens on an edge where both
//                 are high; while ts_valid && !ts_ready the source holds
//                 ts_data, ts_sop, ts_eop and ts_err stable.
interface rs_ts_out_buffer_if;
  logic       CE;
  logic       Valid_in;
  logic [7:0] input_byte;
  logic       ts_ready;
  logic [7:0] ts_data;
  logic       ts_valid;
  logic       ts_sop;
  logic       ts_eop;
  logic       ts_err;

  // Upstream/sink side: drives the decoder bytes and ts_ready.
  modport master (
    output CE, Valid_in, input_byte, ts_ready,
    input  ts_data, ts_valid, ts_sop, ts_eop, ts_err
  );

  // Buffer side.
  modport slave (
    input  CE, Valid_in, input_byte, ts_ready,
    output ts_data, ts_valid, ts_sop, ts_eop, ts_err
  );
endinterface

// File: rtl/rs_ts_out_buffer.sv
// Frames the RS(204,188) decoder byte stream into MPEG-TS packets, checks the
// sync byte, and buffers whole packets in a show-ahead FIFO that drains over a
// valid/ready byte interface. A packet is only admitted when the FIFO has room
// for all of it, so the buffer can never overflow mid-packet.
module rs_ts_out_buffer #(
  parameter int         DEPTH_LOG2 = 9,
  parameter int         BLOCK_LEN  = 188,
  parameter logic [7:0] SYNC_BYTE  = 8'h47
) (
  input  logic                           clk,
  input  logic                           reset,
  rs_ts_out_buffer_if.slave              bus,
  output logic                           pkt_drop,
  output logic                           overflow_flag,
  output logic [DEPTH_LOG2:0]            level,
  output logic [1:0]                     dbg_state,
  output logic [$clog2(BLOCK_LEN)-1:0]   dbg_in_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(BLOCK_LEN);
  localparam logic [CW-1:0]         LAST_IDX  = CW'(BLOCK_LEN - 1);
  // Admit a packet only while level <= DEPTH - BLOCK_LEN (free >= BLOCK_LEN).
  localparam logic [DEPTH_LOG2:0]   ADMIT_MAX = (DEPTH_LOG2 + 1)'(DEPTH - BLOCK_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    DROP  = 2'd2
  } in_state_t;

  // Entry layout: {err, eop, sop, data}
  typedef logic [10:0] entry_t;

  in_state_t             state, state_next;
  logic [CW-1:0]         in_cnt;
  logic                  err_tag;
  logic                  accept;
  logic                  first_byte;
  logic                  last_byte;
  logic                  has_room;
  logic                  wr_en;
  logic                  wr_err;
  logic                  err_load;
  logic                  drop_start;
  entry_t                wr_entry;

  entry_t                mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   mem_cnt;
  logic                  mem_has;
  entry_t                out_entry;
  logic                  out_valid;
  logic                  xfer;
  logic                  load;

  assign accept     = bus.CE & bus.Valid_in;
  assign first_byte = (in_cnt == '0);
  assign last_byte  = (in_cnt == LAST_IDX);
  // Uses the level before this edge; a same-cycle transfer is not credited.
  assign has_room   = (level <= ADMIT_MAX);
  assign wr_entry   = {wr_err, last_byte, first_byte, bus.input_byte};

  // Input state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Input FSM: admit, store or discard each packet as it arrives.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_err     = err_tag;
    err_load   = 1'b0;
    drop_start = 1'b0;
    case (state)
      IDLE: begin
        if (accept && first_byte) begin
          if (has_room) begin
            state_next = STORE;
            wr_en      = 1'b1;
            wr_err     = (bus.input_byte != SYNC_BYTE);
            err_load   = 1'b1;
          end else begin
            state_next = DROP;
            drop_start = 1'b1;
          end
        end
      end
      STORE: begin
        if (accept) begin
          wr_en = 1'b1;
          if (last_byte) state_next = IDLE;
        end
      end
      DROP: begin
        if (accept && last_byte) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte position within the packet; moves only on accepted bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_cnt <= '0;
    end else if (accept) begin
      in_cnt <= last_byte ? '0 : in_cnt + 1'b1;
    end
  end

  // Sync-error tag latched at byte 0 and applied to the whole packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         err_tag <= 1'b0;
    else if (err_load) err_tag <= wr_err;
  end

  // Drop pulse and its sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_drop      <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      pkt_drop      <= drop_start;
      overflow_flag <= overflow_flag | drop_start;
    end
  end

  // FIFO storage; contents are meaningless after reset so it is not cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  // Write pointer, wraps naturally at 2**DEPTH_LOG2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      wr_ptr <= '0;
    else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
  end

  // level covers memory plus the output register, so memory alone holds
  // level minus the output register's occupancy.
  assign mem_cnt = level - {{DEPTH_LOG2{1'b0}}, out_valid};
  assign mem_has = (mem_cnt != '0);
  assign xfer    = out_valid & bus.ts_ready;
  assign load    = mem_has & (~out_valid | xfer);

  // Show-ahead output register: refills whenever it empties or is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_entry <= '0;
      out_valid <= 1'b0;
      rd_ptr    <= '0;
    end else if (load) begin
      out_entry <= mem[rd_ptr];
      out_valid <= 1'b1;
      rd_ptr    <= rd_ptr + 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Occupancy: +1 per write, -1 per transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else begin
      case ({wr_en, xfer})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign bus.ts_data  = out_entry[7:0];
  assign bus.ts_sop   = out_entry[8];
  assign bus.ts_eop   = out_entry[9];
  assign bus.ts_err   = out_entry[10];
  assign bus.ts_valid = out_valid;

  assign dbg_state  = state;
  assign dbg_in_cnt = in_cnt;

endmodule

// File: tb/tb_rs_ts_out_buffer.sv
// Bench for rs_ts_out_buffer: randomized packets, a packet-level reference
// model feeding an expected queue, and a negedge monitor comparing outputs.
module tb_rs_ts_out_buffer;

  localparam int DEPTH_LOG2 = 9;
  localparam int BLOCK_LEN  = 188;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_ts_out_buffer_if bus ();
  logic                 pkt_drop;
  logic                 overflow_flag;
  logic [DEPTH_LOG2:0]  level;
  logic [1:0]           dbg_state;
  logic [7:0]           dbg_in_cnt;

  rs_ts_out_buffer #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .BLOCK_LEN (BLOCK_LEN),
    .SYNC_BYTE (8'h47)
  ) u_dut (
    .clk          (clk),
    .reset        (rst),
    .bus          (bus),
    .pkt_drop     (pkt_drop),
    .overflow_flag(overflow_flag),
    .level        (level),
    .dbg_state    (dbg_state),
    .dbg_in_cnt   (dbg_in_cnt)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Packet-level view: position in packet, whether this packet was admitted,
  // and the number of bytes held by the buffer.
  logic [10:0] exp_q[$];
  int  m_level;
  int  m_pos;
  bit  m_keep;
  bit  m_err;
  bit  m_drop;
  bit  m_ovf;
  bit  m_xfer;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_level = 0;
      m_pos   = 0;
      m_keep  = 0;
      m_err   = 0;
      m_drop  = 0;
      m_ovf   = 0;
    end else begin
      m_xfer = bus.ts_valid && bus.ts_ready;
      m_drop = 0;
      if (bus.CE && bus.Valid_in) begin
        if (m_pos == 0) begin
          if (DEPTH - m_level >= BLOCK_LEN) begin
            m_keep = 1;
            m_err  = (bus.input_byte != 8'h47);
          end else begin
            m_keep = 0;
            m_drop = 1;
            m_ovf  = 1;
          end
        end
        if (m_keep) begin
          exp_q.push_back({m_err, m_pos == BLOCK_LEN - 1, m_pos == 0, bus.input_byte});
          m_level++;
        end
        m_pos = (m_pos + 1) % BLOCK_LEN;
      end
      if (m_xfer) m_level--;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          cnt_xfer = 0;
  int          cnt_sop  = 0;
  int          cnt_eop  = 0;
  bit          stall_pending = 0;
  logic [10:0] held;
  logic [10:0] got;
  logic [10:0] want;

  always @(negedge clk) begin
    if (rst) begin
      stall_pending = 0;
    end else begin
      got = {bus.ts_err, bus.ts_eop, bus.ts_sop, bus.ts_data};
      check("level", 32'(level), 32'(m_level));
      check("pkt_drop", 32'(pkt_drop), 32'(m_drop));
      check("overflow_flag", 32'(overflow_flag), 32'(m_ovf));
      if (stall_pending) begin
        check("stall_valid", 32'(bus.ts_valid), 32'd1);
        check("stall_hold", 32'(got), 32'(held));
      end
      if (bus.ts_valid && bus.ts_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got %0h expected nothing at %0t", got, $time);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_err++;
            $display("FAIL out_entry: got err/eop/sop/data=%0h expected %0h at %0t", got, want, $time);
          end
        end
        cnt_xfer++;
        if (bus.ts_sop) cnt_sop++;
        if (bus.ts_eop) cnt_eop++;
      end
      stall_pending = bus.ts_valid && !bus.ts_ready;
      held          = got;
    end
  end

  // ---------------- sink ready driver ----------------
  int ready_mode  = 0;  // 0: always 1, 1: always 0, 2: 1,0,0,1 pattern, 3: random
  int ready_phase = 0;

  initial begin
    bus.ts_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.ts_ready = 1'b1;
        1: bus.ts_ready = 1'b0;
        2: begin
          bus.ts_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
          ready_phase++;
        end
        default: bus.ts_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted byte followed by gap cycles of CE noise with Valid_in low.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.CE         = 1'b1;
    bus.Valid_in   = 1'b1;
    bus.input_byte = b;
    tick();
    for (int g = 0; g < gap; g++) begin
      bus.CE         = 1'($urandom_range(0, 1));
      bus.Valid_in   = 1'b0;
      bus.input_byte = 8'($urandom_range(0, 255));
      tick();
    end
    bus.CE       = 1'b0;
    bus.Valid_in = 1'b0;
  endtask

  // rnd=0: bytes 1..187 follow b0; rnd=1: random payload.
  task automatic send_packet(input logic [7:0] b0, input bit rnd, input int gap_min,
                             input int gap_max, input int nbytes);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      if (i == 0)   b = b0;
      else if (rnd) b = 8'($urandom_range(0, 255));
      else          b = i[7:0];
      send_byte(b, $urandom_range(gap_min, gap_max));
    end
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || level != 0 || bus.ts_valid) && cyc < 5000) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc >= 5000) begin
      n_err++;
      $display("FAIL %s_drain_timeout: got level=%0d queue=%0d expected 0", name, level, exp_q.size());
    end
  endtask

  task automatic check_reset_values();
    check("rst_ts_data", 32'(bus.ts_data), 32'd0);
    check("rst_ts_valid", 32'(bus.ts_valid), 32'd0);
    check("rst_ts_sop", 32'(bus.ts_sop), 32'd0);
    check("rst_ts_eop", 32'(bus.ts_eop), 32'd0);
    check("rst_ts_err", 32'(bus.ts_err), 32'd0);
    check("rst_pkt_drop", 32'(pkt_drop), 32'd0);
    check("rst_overflow", 32'(overflow_flag), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_in_cnt", 32'(dbg_in_cnt), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // ---------------- main sequence ----------------
  logic [7:0] cnt_before;

  initial begin
    rst            = 1'b1;
    bus.CE         = 1'b0;
    bus.Valid_in   = 1'b0;
    bus.input_byte = 8'h00;
    repeat (3) tick();
    check_reset_values();
    rst = 1'b0;
    tick();

    // Nominal packet, CE one cycle in eight.
    ready_mode = 0;
    cnt_xfer = 0; cnt_sop = 0; cnt_eop = 0;
    send_packet(8'h47, 1'b0, 7, 7, BLOCK_LEN);
    drain("nominal");
    check("nominal_xfers", 32'(cnt_xfer), 32'd188);
    check("nominal_sop", 32'(cnt_sop), 32'd1);
    check("nominal_eop", 32'(cnt_eop), 32'd1);

    // Sync error packet followed by a good one.
    send_packet(8'h00, 1'b1, 0, 2, BLOCK_LEN);
    send_packet(8'h47, 1'b1, 0, 2, BLOCK_LEN);
    drain("sync_err");

    // Drop on full: sink stalled, three back-to-back packets.
    ready_mode = 1;
    tick();
    send_packet(8'h47, 1'b1, 0, 0, BLOCK_LEN);
    send_packet(8'h12, 1'b1, 0, 0, BLOCK_LEN);
    check("full_level_after2", 32'(level), 32'd376);
    send_packet(8'h47, 1'b1, 0, 0, BLOCK_LEN);
    check("full_level_after3", 32'(level), 32'd376);
    check("full_overflow", 32'(overflow_flag), 32'd1);
    cnt_xfer = 0; cnt_sop = 0; cnt_eop = 0;
    ready_mode = 0;
    drain("full");
    check("full_xfers", 32'(cnt_xfer), 32'd376);
    check("full_sop", 32'(cnt_sop), 32'd2);
    check("full_eop", 32'(cnt_eop), 32'd2);

    // Backpressure with 1,0,0,1 ready pattern.
    ready_mode  = 2;
    ready_phase = 0;
    send_packet(8'h47, 1'b1, 0, 1, BLOCK_LEN);
    send_packet(8'h47, 1'b1, 0, 0, BLOCK_LEN);
    drain("backpressure");

    // Random traffic and random sink.
    ready_mode = 3;
    for (int p = 0; p < 4; p++) begin
      send_packet(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h47,
                  1'b1, 0, 3, BLOCK_LEN);
    end
    drain("random");

    // Reset mid-packet.
    ready_mode = 0;
    send_packet(8'h47, 1'b1, 0, 0, 100);
    rst = 1'b1;
    #1;
    check_reset_values();
    tick();
    rst = 1'b0;
    tick();
    cnt_xfer = 0; cnt_sop = 0; cnt_eop = 0;
    send_packet(8'h47, 1'b1, 0, 1, BLOCK_LEN);
    drain("after_reset");
    check("after_reset_xfers", 32'(cnt_xfer), 32'd188);
    check("after_reset_sop", 32'(cnt_sop), 32'd1);

    // Gated CE: strobes with Valid_in low must be ignored.
    cnt_before = dbg_in_cnt;
    for (int k = 0; k < 20; k++) begin
      bus.CE         = 1'b1;
      bus.Valid_in   = 1'b0;
      bus.input_byte = 8'($urandom_range(0, 255));
      tick();
      bus.CE = 1'b0;
      tick();
    end
    check("gated_level", 32'(level), 32'd0);
    check("gated_valid", 32'(bus.ts_valid), 32'd0);
    check("gated_in_cnt", 32'(dbg_in_cnt), 32'(cnt_before));
    cnt_xfer = 0; cnt_sop = 0;
    send_packet(8'h47, 1'b1, 0, 1, BLOCK_LEN);
    drain("gated");
    check("gated_xfers", 32'(cnt_xfer), 32'd188);
    check("gated_sop", 32'(cnt_sop), 32'd1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
